// File: rtl/tm1638_driver.sv
// TM1638 display/key driver: streams digit, LED and brightness data to the chip
// in an endless four-transaction frame and reads the key matrix back each frame.
module tm1638_driver #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] digits,
  input  logic [7:0]  leds,
  input  logic [2:0]  brightness,
  output logic [7:0]  keys,
  output logic        frame_done,
  output logic        tm1638_clk,
  output logic        tm1638_stb,
  input  logic        tm1638_dio_in,
  output logic        tm1638_dio_out,
  output logic        tm1638_dio_out_en
);

  localparam logic [8:0] HALF        = 9'(CLK_DIV);
  localparam logic [8:0] PERIOD_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    GAP       = 2'd0,
    SHIFT_OUT = 2'd1,
    WAIT      = 2'd2,
    SHIFT_IN  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  byte_q, byte_d;
  logic [1:0]  tx_q, tx_d;
  logic [7:0]  key_acc_q, key_acc_d;
  logic [7:0]  keys_q, keys_d;
  logic        frame_done_q, frame_done_d;
  logic        clk_q, clk_d;
  logic        stb_q, stb_d;
  logic        dio_q, dio_d;
  logic        en_q, en_d;

  logic [63:0] snap_digits_q;
  logic [7:0]  snap_leds_q;
  logic [2:0]  snap_bright_q;

  logic [7:0]  data_bytes [16];
  logic [7:0]  tx_byte;
  logic        last_phase;
  logic        last_bit;
  logic        last_out_byte;

  // T2 payload interleaves each digit pattern with its LED flag byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_data
    assign data_bytes[2*gi]   = snap_digits_q[8*gi +: 8];
    assign data_bytes[2*gi+1] = {7'b0, snap_leds_q[gi]};
  end

  assign last_phase    = (phase_q == PERIOD_LAST);
  assign last_bit      = (bit_q == 3'd7);
  assign last_out_byte = (tx_q == 2'd1) ? (byte_q == 5'd16) : (byte_q == 5'd0);

  // Byte selected by the upcoming byte/transaction position.
  always_comb begin
    tx_byte = 8'h00;
    case (tx_d)
      2'd0:    tx_byte = 8'h40;
      2'd1:    tx_byte = (byte_d == 5'd0) ? 8'hC0 : data_bytes[4'(byte_d - 5'd1)];
      2'd2:    tx_byte = {5'b10001, snap_bright_q};
      default: tx_byte = 8'h42;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = last_phase ? 9'd0 : phase_q + 9'd1;
    bit_d        = bit_q;
    byte_d       = byte_q;
    tx_d         = tx_q;
    key_acc_d    = key_acc_q;
    keys_d       = keys_q;
    frame_done_d = 1'b0;
    case (state_q)
      GAP: begin
        if (last_phase) begin
          state_d = SHIFT_OUT;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
        end
      end
      SHIFT_OUT: begin
        if (last_phase) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            if (!last_out_byte) begin
              byte_d = byte_q + 5'd1;
            end else if (tx_q == 2'd3) begin
              state_d = WAIT;
              byte_d  = 5'd0;
            end else begin
              state_d = GAP;
              byte_d  = 5'd0;
              tx_d    = tx_q + 2'd1;
            end
          end
        end
      end
      WAIT: begin
        if (last_phase) begin
          state_d = SHIFT_IN;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
        end
      end
      SHIFT_IN: begin
        if (last_phase) begin
          bit_d = bit_q + 3'd1;
          // Only bits 0 and 4 of each read byte carry key states.
          if (bit_q == 3'd0) key_acc_d[{1'b0, byte_q[1:0]}] = tm1638_dio_in;
          if (bit_q == 3'd4) key_acc_d[{1'b1, byte_q[1:0]}] = tm1638_dio_in;
          if (last_bit) begin
            if (byte_q == 5'd3) begin
              state_d      = GAP;
              tx_d         = 2'd0;
              byte_d       = 5'd0;
              keys_d       = key_acc_d;
              frame_done_d = 1'b1;
            end else begin
              byte_d = byte_q + 5'd1;
            end
          end
        end
      end
      default: state_d = GAP;
    endcase
  end

  // Pin values are decoded from the next state and registered, so the pins are glitch-free.
  always_comb begin
    stb_d = (state_d == GAP);
    en_d  = !((state_d == WAIT) || (state_d == SHIFT_IN));
    clk_d = 1'b1;
    if (((state_d == SHIFT_OUT) || (state_d == SHIFT_IN)) && (phase_d < HALF)) clk_d = 1'b0;
    dio_d = dio_q;
    if (state_d == SHIFT_IN)       dio_d = 1'b0;
    else if (state_d == SHIFT_OUT) dio_d = tx_byte[bit_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= GAP;
      phase_q      <= 9'd0;
      bit_q        <= 3'd0;
      byte_q       <= 5'd0;
      tx_q         <= 2'd0;
      key_acc_q    <= 8'h00;
      keys_q       <= 8'h00;
      frame_done_q <= 1'b0;
      clk_q        <= 1'b1;
      stb_q        <= 1'b1;
      dio_q        <= 1'b0;
      en_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      tx_q         <= tx_d;
      key_acc_q    <= key_acc_d;
      keys_q       <= keys_d;
      frame_done_q <= frame_done_d;
      clk_q        <= clk_d;
      stb_q        <= stb_d;
      dio_q        <= dio_d;
      en_q         <= en_d;
    end
  end

  // Snapshot is taken on the first cycle of T1's gap (held there during reset).
  always_ff @(posedge clock) begin
    if ((state_q == GAP) && (tx_q == 2'd0) && (phase_q == 9'd0)) begin
      snap_digits_q <= digits;
      snap_leds_q   <= leds;
      snap_bright_q <= brightness;
    end
  end

  assign keys              = keys_q;
  assign frame_done        = frame_done_q;
  assign tm1638_clk        = clk_q;
  assign tm1638_stb        = stb_q;
  assign tm1638_dio_out    = dio_q;
  assign tm1638_dio_out_en = en_q;

endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: a TM1638 bus model decodes every transaction and
// scores bytes, bit timing, dio direction, keys and frame cadence each cycle.
module tb_tm1638_driver;
  localparam int CLK_DIV = 4;
  localparam int BP      = 2 * CLK_DIV;
  localparam int FRAME   = 197 * BP;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] digits = '0;
  logic [7:0]  leds = '0;
  logic [2:0]  brightness = '0;
  logic [7:0]  keys;
  logic        frame_done;
  logic        tm_clk, tm_stb, dio_out, dio_en;
  logic        dio_in = 1'b0;

  tm1638_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset(reset), .digits(digits), .leds(leds),
    .brightness(brightness), .keys(keys), .frame_done(frame_done),
    .tm1638_clk(tm_clk), .tm1638_stb(tm_stb), .tm1638_dio_in(dio_in),
    .tm1638_dio_out(dio_out), .tm1638_dio_out_en(dio_en)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  int   cyc = 0;
  bit   rst_edge;
  logic prev_stb = 1'b1, prev_clk = 1'b1, prev_dio = 1'b0;
  bit   in_tx = 0, is_read = 0;
  int   tcyc = 0, high_cnt = 0, bitcnt = 0, rbit = 0;
  logic [7:0] cur_byte;
  logic [7:0] txlog [$];
  int   tx_idx = 0, done_idx = -1, done_count = 0;
  logic [7:0] rd_next [4];
  logic [7:0] rd_cur [4];
  bit   rd_random = 0;
  logic [63:0] snap_digits;
  logic [7:0]  snap_leds;
  logic [2:0]  snap_bright;
  bit   snap_pending = 0;
  logic [7:0] exp_keys = 8'h00;
  int   last_fd_cyc = 0;
  bit   fd_valid = 0;
  bit   churn = 0;

  // One clock of the bus model; outputs sampled on the falling edge.
  task automatic step();
    logic [7:0] exp_b [$];
    logic exp_fd, exp_clk, exp_en, t4, bad_dio;
    int mism;
    if (churn && $urandom_range(0, 99) < 3) begin
      digits = {$urandom, $urandom};
      leds = 8'($urandom);
      brightness = 3'($urandom);
    end
    if (snap_pending) begin
      snap_digits = digits; snap_leds = leds; snap_bright = brightness;
      snap_pending = 0;
    end
    @(posedge clock);
    rst_edge = reset;
    @(negedge clock);
    cyc++;
    if (rst_edge) begin
      in_tx = 0; is_read = 0; tx_idx = 0; high_cnt = 1; exp_keys = 8'h00;
      fd_valid = 0; snap_pending = 1; dio_in = 1'b0;
      checks++;
      if ({tm_stb, tm_clk, dio_out, dio_en, keys, frame_done} !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0}) begin
        $display("FAIL reset_outputs: got stb=%b clk=%b dio=%b en=%b keys=%h fd=%b want 1 1 0 1 00 0",
                 tm_stb, tm_clk, dio_out, dio_en, keys, frame_done);
      end else passes++;
    end else begin
      exp_fd = 1'b0;
      if (prev_stb && !tm_stb) begin
        checks++;
        if (high_cnt !== BP) $display("FAIL gap_length: got %0d want %0d", high_cnt, BP);
        else passes++;
        in_tx = 1; tcyc = 0; bitcnt = 0; rbit = 0; is_read = 0; txlog.delete();
        if (tx_idx == 3) begin
          rd_cur = rd_next;
          if (rd_random) for (int j = 0; j < 4; j++) rd_next[j] = 8'($urandom);
        end
      end else if (!prev_stb && tm_stb && in_tx) begin
        in_tx = 0; is_read = 0; high_cnt = 1;
        case (tx_idx)
          0: exp_b = {8'h40};
          1: begin
            exp_b = {8'hC0};
            for (int i = 0; i < 8; i++) begin
              exp_b.push_back(snap_digits[8*i +: 8]);
              exp_b.push_back({7'b0, snap_leds[i]});
            end
          end
          2: exp_b = {8'h88 | {5'b0, snap_bright}};
          default: exp_b = {8'h42};
        endcase
        mism = -1;
        if (txlog.size() != exp_b.size()) mism = txlog.size();
        else for (int i = 0; i < exp_b.size(); i++) if (mism < 0 && txlog[i] !== exp_b[i]) mism = i;
        checks++;
        if (mism >= 0)
          $display("FAIL tx%0d_bytes: at byte %0d got %h (len %0d) want %h (len %0d)", tx_idx + 1, mism,
                   (mism < txlog.size()) ? txlog[mism] : 8'hxx, txlog.size(),
                   (mism < exp_b.size()) ? exp_b[mism] : 8'hxx, exp_b.size());
        else passes++;
        checks++;
        if (tcyc + 1 !== exp_b.size() * 8 * BP + ((tx_idx == 3) ? 33 * BP : 0))
          $display("FAIL tx%0d_stb_low: got %0d want %0d", tx_idx + 1, tcyc + 1,
                   exp_b.size() * 8 * BP + ((tx_idx == 3) ? 33 * BP : 0));
        else passes++;
        if (tx_idx == 3) begin
          exp_fd = 1'b1;
          for (int j = 0; j < 4; j++) begin
            exp_keys[j] = rd_cur[j][0];
            exp_keys[j+4] = rd_cur[j][4];
          end
          if (fd_valid) begin
            checks++;
            if (cyc - last_fd_cyc !== FRAME) $display("FAIL frame_period: got %0d want %0d", cyc - last_fd_cyc, FRAME);
            else passes++;
          end
          last_fd_cyc = cyc; fd_valid = 1; snap_pending = 1;
        end
        done_idx = tx_idx; done_count++; tx_idx = (tx_idx + 1) % 4;
      end else if (tm_stb) begin
        high_cnt++;
      end else if (in_tx) begin
        tcyc++;
      end

      if (in_tx) begin
        t4 = (tx_idx == 3) && (tcyc >= 8 * BP);
        exp_clk = (t4 && tcyc < 9 * BP) ? 1'b1 : ((tcyc % BP) >= CLK_DIV);
        exp_en = !t4;
      end else begin
        t4 = 1'b0; exp_clk = 1'b1; exp_en = 1'b1;
        dio_in = 1'($urandom);
      end
      checks++;
      if ({tm_clk, dio_en} !== {exp_clk, exp_en})
        $display("FAIL clk_en cyc=%0d tcyc=%0d: got clk=%b en=%b want clk=%b en=%b", cyc, tcyc, tm_clk, dio_en, exp_clk, exp_en);
      else passes++;
      checks++;
      if ({frame_done, keys} !== {exp_fd, exp_keys})
        $display("FAIL keys_fd cyc=%0d: got fd=%b keys=%h want fd=%b keys=%h", cyc, frame_done, keys, exp_fd, exp_keys);
      else passes++;
      bad_dio = (prev_clk && tm_clk && dio_out !== prev_dio) || (in_tx && t4 && tcyc >= 9 * BP && dio_out !== 1'b0);
      checks++;
      if (bad_dio) $display("FAIL dio_rule cyc=%0d: got dio=%b clk=%b (prev dio=%b) want stable while clk high, 0 in read",
                            cyc, dio_out, tm_clk, prev_dio);
      else passes++;

      if (in_tx && !is_read && !prev_clk && tm_clk) begin
        cur_byte[bitcnt % 8] = dio_out;
        bitcnt++;
        if (bitcnt % 8 == 0) txlog.push_back(cur_byte);
        if (tx_idx == 3 && bitcnt == 8) is_read = 1;
      end else if (in_tx && is_read && prev_clk && !tm_clk && rbit < 32) begin
        dio_in = rd_cur[rbit / 8][rbit % 8];
        rbit++;
      end
    end
    prev_stb = tm_stb; prev_clk = tm_clk; prev_dio = dio_out;
  endtask

  task automatic wait_fd(input int lim, output int n);
    n = 0;
    do begin step(); n++; end while (frame_done !== 1'b1 && n < lim);
    if (frame_done !== 1'b1) begin
      checks++;
      $display("FAIL wait_frame_done: got none in %0d cycles want a pulse", lim);
    end
  endtask

  task automatic wait_tx(input int idx, input int lim);
    int start, n;
    start = done_count; n = 0;
    do begin step(); n++; end while (!(done_count != start && done_idx == idx) && n < lim);
    if (!(done_count != start && done_idx == idx)) begin
      checks++;
      $display("FAIL wait_tx%0d: got no completion in %0d cycles want one", idx + 1, lim);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (tm_stb === 1'b1 && n < 40);
    checks++;
    if (n !== 8) $display("FAIL first_stb_fall: got cycle %0d want 8", n);
    else passes++;
    n = 0;
    while (tm_stb === 1'b0 && n < 200) begin step(); n++; end
    checks++;
    if (8 + n !== 72) $display("FAIL first_stb_rise: got cycle %0d want 72", 8 + n);
    else passes++;
    checks++;
    if (txlog.size() !== 1 || txlog[0] !== 8'h40) $display("FAIL t1_byte: got %h (len %0d) want 40", txlog[0], txlog.size());
    else passes++;
  endtask

  task automatic test_t2_pattern();
    logic [7:0] exp_t2 [17];
    int n, bad;
    exp_t2 = '{8'hC0, 8'h08, 8'h01, 8'h07, 8'h00, 8'h06, 8'h00, 8'h05, 8'h00,
               8'h04, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'h01, 8'h01};
    digits = 64'h0102030405060708;
    leds = 8'h81;
    wait_fd(2 * FRAME, n);
    wait_tx(1, FRAME);
    bad = -1;
    if (txlog.size() != 17) bad = 99;
    else for (int i = 0; i < 17; i++) if (bad < 0 && txlog[i] !== exp_t2[i]) bad = i;
    checks++;
    if (bad >= 0) $display("FAIL t2_stream: first bad byte %0d got %h want %h", bad, (bad < txlog.size()) ? txlog[bad] : 8'hxx,
                           (bad < 17) ? exp_t2[bad] : 8'hxx);
    else passes++;
  endtask

  task automatic test_brightness();
    int n;
    brightness = 3'd5;
    wait_fd(2 * FRAME, n);
    wait_tx(0, FRAME);
    brightness = 3'd2;
    wait_tx(2, FRAME);
    checks++;
    if (txlog[0] !== 8'h8D) $display("FAIL t3_current_frame: got %h want 8d", txlog[0]);
    else passes++;
    wait_tx(2, 2 * FRAME);
    checks++;
    if (txlog[0] !== 8'h8A) $display("FAIL t3_next_frame: got %h want 8a", txlog[0]);
    else passes++;
  endtask

  task automatic test_keys();
    int n;
    rd_random = 0;
    rd_next = '{8'h01, 8'h10, 8'h00, 8'h11};
    wait_fd(2 * FRAME, n);
    wait_fd(2 * FRAME, n);
    checks++;
    if (keys !== 8'b1010_1001) $display("FAIL keys_map: got %b want 10101001", keys);
    else passes++;
    wait_fd(2 * FRAME, n);
    checks++;
    if (n !== FRAME) $display("FAIL fd_interval: got %0d want %0d", n, FRAME);
    else passes++;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] base [4];
    int n;
    base = '{8'h10, 8'h01, 8'h10, 8'h01};
    for (int j = 0; j < 4; j++) rd_next[j] = base[j] | (8'($urandom) & 8'hEE);
    wait_fd(2 * FRAME, n);
    wait_fd(2 * FRAME, n);
    checks++;
    if (keys !== 8'h5A) $display("FAIL keys_before_abort: got %h want 5a", keys);
    else passes++;
    n = 0;
    while (!(in_tx && tx_idx == 3) && n < 2 * FRAME) begin step(); n++; end
    while (in_tx && tcyc < 9 * BP + 16 * BP + 20 && n < 2 * FRAME) begin step(); n++; end
    reset = 1'b1;
    step();
    checks++;
    if ({tm_stb, tm_clk, keys, dio_en} !== {1'b1, 1'b1, 8'h00, 1'b1})
      $display("FAIL abort_state: got stb=%b clk=%b keys=%h en=%b want 1 1 00 1", tm_stb, tm_clk, keys, dio_en);
    else passes++;
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (tm_stb === 1'b1 && n < 40);
    checks++;
    if (n !== 8) $display("FAIL restart_stb_fall: got cycle %0d want 8", n);
    else passes++;
    wait_tx(2, FRAME);
    checks++;
    if (keys !== 8'h00) $display("FAIL keys_after_abort: got %h want 00", keys);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int n;
    rd_random = 1;
    for (int j = 0; j < 4; j++) rd_next[j] = 8'($urandom);
    churn = 1;
    repeat (3) wait_fd(2 * FRAME, n);
    churn = 0;
  endtask

  initial begin
    test_reset();
    test_t2_pattern();
    test_brightness();
    test_keys();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
